// File: rtl/wm_panel_ctrl.sv
// -----------------------------------------------------------------------------
// wm_panel_ctrl
// Front-panel input conditioner for the washing machine controller.
// Four raw push-buttons (power, start, pause, mode) are synchronized and
// debounced. Each accepted press becomes a one-cycle event that drives a small
// run-status FSM (OFF / READY / RUNNING / PAUSED). The FSM produces the
// controller's power/start/pause/mode inputs. It locks out illegal presses
// mid-cycle and flags them with a one-cycle beep.
//
// Ports
//   clk            in   system clock, rising edge
//   reset          in   synchronous active-low reset
//   btn_*_raw      in   raw asynchronous buttons, 1 = pressed
//   door_closed    in   door switch (synchronous), 1 = closed
//   done           in   cycle-complete level from the washing controller
//   power          out  power enable (registered)
//   start          out  one-cycle start pulse (registered)
//   pause          out  pause level (registered)
//   mode           out  wash mode 00 quick / 01 normal / 10 heavy (registered)
//   busy           out  1 while RUNNING or PAUSED (registered)
//   beep           out  one-cycle pulse on a rejected press (registered)
// -----------------------------------------------------------------------------
module wm_panel_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES   = 4,
  parameter int unsigned LONG_PRESS_CYCLES = 16,
  parameter int unsigned CNT_W             = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_power_raw,
  input  logic       btn_start_raw,
  input  logic       btn_pause_raw,
  input  logic       btn_mode_raw,
  input  logic       door_closed,
  input  logic       done,
  output logic       power,
  output logic       start,
  output logic       pause,
  output logic [1:0] mode,
  output logic       busy,
  output logic       beep
);

  localparam int NB      = 4;
  localparam int B_POWER = 0;
  localparam int B_START = 1;
  localparam int B_PAUSE = 2;
  localparam int B_MODE  = 3;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_READY   = 2'd1,
    ST_RUNNING = 2'd2,
    ST_PAUSED  = 2'd3
  } state_t;

  // Wash mode sequence quick -> normal -> heavy -> quick; 11 is never produced.
  function automatic logic [1:0] mode_step(input logic [1:0] m);
    logic [1:0] r;
    case (m)
      2'b00:   r = 2'b01;
      2'b01:   r = 2'b10;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Button conditioning: 2-flop sync, counting debouncer, rising-edge event
  // ---------------------------------------------------------------------------
  logic [NB-1:0]            raw_s;
  logic [NB-1:0]            sync1_q, sync2_q;
  logic [NB-1:0]            deb_q, deb_d;
  logic [NB-1:0]            deb_prev_q;
  logic [NB-1:0]            evt_q;
  logic [NB-1:0][CNT_W-1:0] db_cnt_q, db_cnt_d;

  assign raw_s = {btn_mode_raw, btn_pause_raw, btn_start_raw, btn_power_raw};

  // Debounce next-state: level changes only after DEBOUNCE_CYCLES consecutive
  // synced samples that disagree with the current debounced level.
  always_comb begin
    deb_d    = deb_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < NB; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        deb_d[i]    = sync2_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end

  // Conditioning registers; the event is registered so the FSM sees it one
  // cycle after the debounced rise.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      evt_q      <= '0;
      db_cnt_q   <= '0;
    end else begin
      sync1_q    <= raw_s;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      evt_q      <= deb_q & ~deb_prev_q;
      db_cnt_q   <= db_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Run-status FSM with registered outputs
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] lp_cnt_q, lp_cnt_d;
  logic             power_q, power_d;
  logic             start_q, start_d;
  logic             pause_q, pause_d;
  logic             busy_q, busy_d;
  logic             beep_q, beep_d;
  logic             busy_st_s;
  logic             lp_hit_s;

  assign busy_st_s = (state_q == ST_RUNNING) || (state_q == ST_PAUSED);
  // Long hold fires on the cycle the hold length reaches LONG_PRESS_CYCLES.
  assign lp_hit_s  = busy_st_s && deb_q[B_POWER] && (lp_cnt_q == LP_LAST);

  // Next state and outputs. Event priority is power > start > pause > mode;
  // in the busy states a long power hold and then cycle completion come first.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    armed_d = armed_q;
    start_d = 1'b0;
    beep_d  = 1'b0;

    case (state_q)
      ST_OFF: begin
        if (evt_q[B_POWER]) begin
          state_d = ST_READY;
        end else begin
          state_d = ST_OFF;
        end
      end

      ST_READY: begin
        if (evt_q[B_POWER]) begin
          state_d = ST_OFF;
        end else if (evt_q[B_START]) begin
          // A same-cycle mode event is dropped here: mode freezes once busy.
          if (door_closed) begin
            state_d = ST_RUNNING;
            start_d = 1'b1;
            armed_d = 1'b0;
          end else begin
            beep_d  = 1'b1;
          end
        end else if (evt_q[B_PAUSE]) begin
          state_d = ST_READY;
        end else if (evt_q[B_MODE]) begin
          mode_d  = mode_step(mode_q);
        end else begin
          state_d = ST_READY;
        end
      end

      ST_RUNNING: begin
        if (lp_hit_s) begin
          state_d = ST_OFF;
        end else if (done && armed_q) begin
          state_d = ST_READY;
        end else begin
          // A stale done from the previous cycle must drop before completion counts.
          if (!done) begin
            armed_d = 1'b1;
          end else begin
            armed_d = armed_q;
          end
          if (evt_q[B_POWER] || evt_q[B_START]) begin
            beep_d  = 1'b1;
          end else if (evt_q[B_PAUSE]) begin
            state_d = ST_PAUSED;
          end else if (evt_q[B_MODE]) begin
            beep_d  = 1'b1;
          end else begin
            state_d = ST_RUNNING;
          end
        end
      end

      ST_PAUSED: begin
        if (lp_hit_s) begin
          state_d = ST_OFF;
        end else if (evt_q[B_POWER] || evt_q[B_START]) begin
          beep_d  = 1'b1;
        end else if (evt_q[B_PAUSE]) begin
          state_d = ST_RUNNING;
        end else if (evt_q[B_MODE]) begin
          beep_d  = 1'b1;
        end else begin
          state_d = ST_PAUSED;
        end
      end

      default: begin
        state_d = ST_OFF;
      end
    endcase

    power_d = (state_d != ST_OFF);
    busy_d  = (state_d == ST_RUNNING) || (state_d == ST_PAUSED);
    pause_d = (state_d == ST_PAUSED);

    // Long-press counter: held power while busy; clears on release or state change.
    if (busy_st_s && deb_q[B_POWER] && (state_d == state_q)) begin
      if (lp_cnt_q == CNT_MAX) begin
        lp_cnt_d = lp_cnt_q;
      end else begin
        lp_cnt_d = lp_cnt_q + 1'b1;
      end
    end else begin
      lp_cnt_d = '0;
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_OFF;
      mode_q   <= 2'b01;
      armed_q  <= 1'b0;
      lp_cnt_q <= '0;
      power_q  <= 1'b0;
      start_q  <= 1'b0;
      pause_q  <= 1'b0;
      busy_q   <= 1'b0;
      beep_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      armed_q  <= armed_d;
      lp_cnt_q <= lp_cnt_d;
      power_q  <= power_d;
      start_q  <= start_d;
      pause_q  <= pause_d;
      busy_q   <= busy_d;
      beep_q   <= beep_d;
    end
  end

  assign power = power_q;
  assign start = start_q;
  assign pause = pause_q;
  assign mode  = mode_q;
  assign busy  = busy_q;
  assign beep  = beep_q;

endmodule

// File: tb/tb_wm_panel_ctrl.sv
// Testbench for wm_panel_ctrl: hand-written latency/reset sequence, a table of
// scenario rows with constant expectations, and a randomized phase checked
// every cycle against a behavioural model of the panel rules.
module tb_wm_panel_ctrl;

  localparam int DEB = 4;
  localparam int LPC = 16;
  localparam int M_OFF = 0, M_READY = 1, M_RUN = 2, M_PAUSE = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, bp, bs, bu, bm, door, done_i;
  logic power, start, pause, busy, beep;
  logic [1:0] mode;

  wm_panel_ctrl #(.DEBOUNCE_CYCLES(DEB), .LONG_PRESS_CYCLES(LPC), .CNT_W(8)) dut (
    .clk(clk), .reset(rst_n),
    .btn_power_raw(bp), .btn_start_raw(bs), .btn_pause_raw(bu), .btn_mode_raw(bm),
    .door_closed(door), .done(done_i),
    .power(power), .start(start), .pause(pause), .mode(mode), .busy(busy), .beep(beep)
  );

  int checks = 0;
  int errors = 0;
  int tick_no = 0;
  int beep_cnt = 0;
  int start_cnt = 0;

  // ---------------- behavioural model ----------------
  int       m_state;
  bit [1:0] m_mode;
  bit       m_armed;
  int       m_lp;
  bit       m_beep, m_start;
  bit       m_valid = 1'b0;
  bit [1:0]     m_pipe [4];  // [0] newest raw sample, [1] the synced one
  bit [DEB-1:0] m_win  [4];  // last DEB synced samples
  bit [2:0]     m_debh [4];  // debounced history, [0] newest

  task automatic model_edge();
    bit raw [4];
    bit ev  [4];
    bit debp, syn, cur;
    int ns;
    raw[0] = bp; raw[1] = bs; raw[2] = bu; raw[3] = bm;
    if (!rst_n) begin
      for (int b = 0; b < 4; b++) begin
        m_pipe[b] = '0; m_win[b] = '0; m_debh[b] = '0;
      end
      m_state = M_OFF; m_mode = 2'b01; m_armed = 1'b0; m_lp = 0;
      m_beep = 1'b0; m_start = 1'b0; m_valid = 1'b1;
      return;
    end
    for (int b = 0; b < 4; b++) ev[b] = m_debh[b][1] & ~m_debh[b][2];
    debp = m_debh[0][0];
    m_beep = 1'b0; m_start = 1'b0; ns = m_state;
    case (m_state)
      M_OFF: if (ev[0]) ns = M_READY;
      M_READY: begin
        if (ev[0]) ns = M_OFF;
        else if (ev[1]) begin
          if (door) begin ns = M_RUN; m_start = 1'b1; m_armed = 1'b0; end
          else m_beep = 1'b1;
        end else if (!ev[2] && ev[3]) m_mode = (m_mode == 2'd2) ? 2'd0 : m_mode + 2'd1;
      end
      default: begin
        if (debp && m_lp == LPC - 1) ns = M_OFF;
        else if (m_state == M_RUN && done_i && m_armed) ns = M_READY;
        else begin
          if (m_state == M_RUN && !done_i) m_armed = 1'b1;
          if (ev[0] || ev[1]) m_beep = 1'b1;
          else if (ev[2]) ns = (m_state == M_RUN) ? M_PAUSE : M_RUN;
          else if (ev[3]) m_beep = 1'b1;
        end
      end
    endcase
    if ((m_state == M_RUN || m_state == M_PAUSE) && debp && ns == m_state)
      m_lp = (m_lp < 255) ? m_lp + 1 : m_lp;
    else
      m_lp = 0;
    m_state = ns;
    for (int b = 0; b < 4; b++) begin
      syn = m_pipe[b][1];
      m_pipe[b] = {m_pipe[b][0], raw[b]};
      cur = m_debh[b][0];
      m_win[b] = {m_win[b][DEB-2:0], syn};
      if (m_win[b] == {DEB{~cur}}) cur = ~cur;
      m_debh[b] = {m_debh[b][1:0], cur};
    end
  endtask

  task automatic tick();
    logic [6:0] got, exp;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    tick_no++;
    if (beep)  beep_cnt++;
    if (start) start_cnt++;
    if (m_valid) begin
      got = {power, start, pause, busy, beep, mode};
      exp = {m_state != M_OFF, m_start, m_state == M_PAUSE,
             m_state == M_RUN || m_state == M_PAUSE, m_beep, m_mode};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL model_cmp tick %0d: dut {pwr,st,pa,busy,beep,mode}=%b expected %b",
                 tick_no, got, exp);
      end
    end
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // ---------------- scenario table ----------------
  typedef struct {
    bit r, p, s, u, m, dr, dn;
    int n;
    bit e_power, e_busy, e_pause;
    bit [1:0] e_mode;
    int e_beeps, e_starts;
  } vec_t;
  vec_t vecs [$];

  initial begin
    logic [3:0] rb;
    int hold [4];
    int dhold;

    //                r p s u m dr dn  n  pw by pa mode  bp st
    vecs.push_back('{1,0,0,0,0,0,0,  8, 1,0,0,2'b01, 0,0}); // release power
    vecs.push_back('{1,0,0,0,1,0,0,  8, 1,0,0,2'b10, 0,0}); // mode 01->10
    vecs.push_back('{1,0,0,0,0,0,0,  8, 1,0,0,2'b10, 0,0});
    vecs.push_back('{1,0,0,0,1,0,0,  8, 1,0,0,2'b00, 0,0}); // 10->00
    vecs.push_back('{1,0,0,0,0,0,0,  8, 1,0,0,2'b00, 0,0});
    vecs.push_back('{1,0,0,0,1,0,0,  8, 1,0,0,2'b01, 0,0}); // 00->01
    vecs.push_back('{1,0,0,0,0,0,0,  8, 1,0,0,2'b01, 0,0});
    vecs.push_back('{1,0,0,0,1,0,0,  2, 1,0,0,2'b01, 0,0}); // glitch
    vecs.push_back('{1,0,0,0,0,0,0,  8, 1,0,0,2'b01, 0,0});
    vecs.push_back('{1,0,1,0,0,0,0,  8, 1,0,0,2'b01, 1,0}); // start, door open
    vecs.push_back('{1,0,0,0,0,0,0,  8, 1,0,0,2'b01, 0,0});
    vecs.push_back('{1,0,1,0,0,1,0,  8, 1,1,0,2'b01, 0,1}); // start, door closed
    vecs.push_back('{1,0,0,0,0,1,0,  8, 1,1,0,2'b01, 0,0});
    vecs.push_back('{1,0,0,1,0,1,0,  8, 1,1,1,2'b01, 0,0}); // pause
    vecs.push_back('{1,0,0,0,0,1,0,  8, 1,1,1,2'b01, 0,0});
    vecs.push_back('{1,0,0,0,0,1,1,  8, 1,1,1,2'b01, 0,0}); // done ignored paused
    vecs.push_back('{1,0,0,0,0,1,0,  4, 1,1,1,2'b01, 0,0});
    vecs.push_back('{1,0,0,1,0,1,0,  8, 1,1,0,2'b01, 0,0}); // resume
    vecs.push_back('{1,0,0,0,0,1,0,  8, 1,1,0,2'b01, 0,0});
    vecs.push_back('{1,0,0,0,0,1,1,  4, 1,0,0,2'b01, 0,0}); // done -> READY
    vecs.push_back('{1,0,1,0,0,1,0,  8, 1,1,0,2'b01, 0,1}); // run again
    vecs.push_back('{1,0,0,0,0,1,0,  8, 1,1,0,2'b01, 0,0});
    vecs.push_back('{1,0,0,0,1,1,0,  8, 1,1,0,2'b01, 1,0}); // mode rejected
    vecs.push_back('{1,0,0,0,0,1,0,  8, 1,1,0,2'b01, 0,0});
    vecs.push_back('{1,0,1,0,0,1,0,  8, 1,1,0,2'b01, 1,0}); // start rejected
    vecs.push_back('{1,0,0,0,0,1,0,  8, 1,1,0,2'b01, 0,0});
    vecs.push_back('{1,1,0,0,0,1,0, 30, 0,0,0,2'b01, 1,0}); // long power hold
    vecs.push_back('{1,0,0,0,0,1,0,  8, 0,0,0,2'b01, 0,0});
    vecs.push_back('{1,1,0,0,0,1,0,  8, 1,0,0,2'b01, 0,0}); // power on
    vecs.push_back('{1,0,0,0,0,1,0,  8, 1,0,0,2'b01, 0,0});
    vecs.push_back('{1,1,1,0,0,1,0,  8, 0,0,0,2'b01, 0,0}); // power+start: power wins
    vecs.push_back('{1,0,0,0,0,1,0,  8, 0,0,0,2'b01, 0,0});
    vecs.push_back('{1,1,0,0,0,1,0,  8, 1,0,0,2'b01, 0,0});
    vecs.push_back('{1,0,0,0,0,1,0,  8, 1,0,0,2'b01, 0,0});
    vecs.push_back('{1,0,0,0,1,1,0,  8, 1,0,0,2'b10, 0,0});
    vecs.push_back('{1,0,0,0,0,1,0,  8, 1,0,0,2'b10, 0,0});
    vecs.push_back('{1,0,1,0,0,1,0,  8, 1,1,0,2'b10, 0,1});
    vecs.push_back('{0,0,0,0,0,1,0,  1, 0,0,0,2'b01, 0,0}); // reset mid-run
    vecs.push_back('{1,0,0,0,0,1,0,  4, 0,0,0,2'b01, 0,0});

    // Hand sequence: reset values, then exact power-on latency.
    rst_n = 1'b0; bp = 1'b0; bs = 1'b0; bu = 1'b0; bm = 1'b0; door = 1'b0; done_i = 1'b0;
    @(negedge clk);
    tick(); tick();
    check("reset_power", int'(power), 0);
    check("reset_busy",  int'(busy),  0);
    check("reset_pause", int'(pause), 0);
    check("reset_start", int'(start), 0);
    check("reset_beep",  int'(beep),  0);
    check("reset_mode",  int'(mode),  1);
    rst_n = 1'b1; bp = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 7) check("power_before_latency", int'(power), 0);
      if (k == 8) check("power_at_latency", int'(power), 1);
    end
    check("ready_busy", int'(busy), 0);
    check("ready_mode", int'(mode), 1);

    // Table rows.
    foreach (vecs[i]) begin
      rst_n = vecs[i].r; bp = vecs[i].p; bs = vecs[i].s; bu = vecs[i].u; bm = vecs[i].m;
      door = vecs[i].dr; done_i = vecs[i].dn;
      beep_cnt = 0; start_cnt = 0;
      for (int k = 0; k < vecs[i].n; k++) tick();
      check($sformatf("row%0d_power", i), int'(power), int'(vecs[i].e_power));
      check($sformatf("row%0d_busy",  i), int'(busy),  int'(vecs[i].e_busy));
      check($sformatf("row%0d_pause", i), int'(pause), int'(vecs[i].e_pause));
      check($sformatf("row%0d_mode",  i), int'(mode),  int'(vecs[i].e_mode));
      check($sformatf("row%0d_beeps", i), beep_cnt,    vecs[i].e_beeps);
      check($sformatf("row%0d_starts", i), start_cnt,  vecs[i].e_starts);
    end

    // Randomized phase against the model.
    rb = 4'b0000;
    for (int b = 0; b < 4; b++) hold[b] = 1;
    dhold = 1;
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 4; b++) begin
        if (hold[b] == 0) begin
          rb[b] = ~rb[b];
          hold[b] = (b == 0) ? int'($urandom_range(60, 1)) : int'($urandom_range(12, 1));
        end else begin
          hold[b]--;
        end
      end
      bp = rb[0]; bs = rb[1]; bu = rb[2]; bm = rb[3];
      if (dhold == 0) begin
        done_i = ~done_i;
        dhold = int'($urandom_range(30, 1));
      end else begin
        dhold--;
      end
      if ($urandom_range(40, 0) == 0) door = ($urandom_range(3, 0) != 0);
      rst_n = ($urandom_range(1500, 0) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
